button_event: RTL

//  Consumes the debounced button level and turns it into one-cycle event pulses:

---
 rtl/button_event_pkg.sv | 18 +
 rtl/button_event_ms_tick_gen.sv | 28 ++
 rtl/button_event.sv | 134 +++++++++++++
 3 files changed

// File: rtl/button_event_pkg.sv
// Shared definitions for the button UI blocks: FSM state encoding and the
// default timing constants for a 50 MHz clock.
package button_event_pkg;

    typedef enum logic [1:0] {
        WAIT_REL = 2'd0,
        IDLE     = 2'd1,
        DELAY    = 2'd2,
        REPEAT   = 2'd3
    } state_t;

    localparam int DEF_TICK_DVSR       = 50000;
    localparam int DEF_LONG_MS         = 1000;
    localparam int DEF_REPEAT_DELAY_MS = 500;
    localparam int DEF_REPEAT_MS       = 100;
    localparam int DEF_CNT_W           = 16;

endpackage

// File: rtl/button_event_ms_tick_gen.sv
// Millisecond prescaler: tick is high while the count sits at DVSR-1, then the
// count wraps. clr restarts the count so the first tick lands DVSR cycles later.
module ms_tick_gen #(
    parameter int DVSR = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int W = (DVSR > 1) ? $clog2(DVSR) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DVSR - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into registered press/release/long-press/
// auto-repeat pulses plus a saturating hold time in ms.
// release and repeat are SystemVerilog keywords, hence release_pulse/repeat_pulse.
module button_event
    import button_event_pkg::*;
#(
    parameter int TICK_DVSR       = DEF_TICK_DVSR,
    parameter int LONG_MS         = DEF_LONG_MS,
    parameter int REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
    parameter int REPEAT_MS       = DEF_REPEAT_MS,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             db,
    input  logic             en,
    output logic             press,
    output logic             release_pulse,
    output logic             long_press,
    output logic             repeat_pulse,
    output logic             held,
    output logic [CNT_W-1:0] hold_ms
);

    localparam logic [CNT_W-1:0] HOLD_MAX = '1;

    state_t           state, state_n;
    logic [CNT_W-1:0] rep_cnt, rep_n;
    logic [CNT_W-1:0] hold_n, hold_inc;
    logic             long_fired, fired_n;
    logic             press_n, release_n, long_n, repeat_n, held_n;
    logic             clr, tick;

    ms_tick_gen #(.DVSR(TICK_DVSR)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .tick  (tick)
    );

    assign hold_inc = (hold_ms == HOLD_MAX) ? hold_ms : hold_ms + 1'b1;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_n   = state;
        hold_n    = hold_ms;
        rep_n     = rep_cnt;
        fired_n   = long_fired;
        held_n    = held;
        press_n   = 1'b0;
        release_n = 1'b0;
        long_n    = 1'b0;
        repeat_n  = 1'b0;
        clr       = 1'b0;

        if (!en) begin
            state_n = WAIT_REL;
            held_n  = 1'b0;
        end else begin
            case (state)
                WAIT_REL: begin
                    held_n = 1'b0;
                    if (!db) state_n = IDLE;
                end
                IDLE: begin
                    if (db) begin
                        state_n = DELAY;
                        press_n = 1'b1;
                        held_n  = 1'b1;
                        hold_n  = '0;
                        rep_n   = '0;
                        fired_n = 1'b0;
                        clr     = 1'b1;
                    end
                end
                DELAY, REPEAT: begin
                    // A release on the threshold tick wins: hold_ms stays frozen.
                    if (!db) begin
                        state_n   = IDLE;
                        release_n = 1'b1;
                        held_n    = 1'b0;
                    end else if (tick) begin
                        hold_n = hold_inc;
                        if (hold_inc == CNT_W'(LONG_MS) && !long_fired) begin
                            long_n  = 1'b1;
                            fired_n = 1'b1;
                        end
                        if (state == DELAY) begin
                            if (hold_inc == CNT_W'(REPEAT_DELAY_MS)) begin
                                state_n  = REPEAT;
                                repeat_n = 1'b1;
                                rep_n    = '0;
                            end
                        end else if (rep_cnt == CNT_W'(REPEAT_MS - 1)) begin
                            repeat_n = 1'b1;
                            rep_n    = '0;
                        end else begin
                            rep_n = rep_cnt + 1'b1;
                        end
                    end
                end
                default: state_n = WAIT_REL;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= WAIT_REL;
            hold_ms       <= '0;
            rep_cnt       <= '0;
            long_fired    <= 1'b0;
            held          <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state         <= state_n;
            hold_ms       <= hold_n;
            rep_cnt       <= rep_n;
            long_fired    <= fired_n;
            held          <= held_n;
            press         <= press_n;
            release_pulse <= release_n;
            long_press    <= long_n;
            repeat_pulse  <= repeat_n;
        end
    end

endmodule
